// File: rtl/ppu_bg_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ppu_bg_fetch_sequencer
// Purpose  : Per-dot background tile fetch sequencer (NT, AT, PT-lo, PT-hi)
//            driving the bg shifters and loopy-v scroll update pulses.
// Revision : 1.0  initial release
// ============================================================================
module ppu_bg_fetch_sequencer #(
    parameter logic [13:0] NT_BASE   = 14'h2000,
    parameter logic [13:0] AT_OFFSET = 14'h03C0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ce,
    input  logic        i_rendering_enabled,
    input  logic        i_render_line,
    input  logic        i_prerender,
    input  logic [8:0]  i_dot,
    input  logic [14:0] i_v,
    input  logic        i_bg_table,
    output logic [13:0] o_vram_addr,
    output logic        o_vram_rd,
    input  logic [7:0]  i_vram_data,
    output logic        o_bg_load,
    output logic        o_bg_shift,
    output logic [7:0]  o_pattern_lo,
    output logic [7:0]  o_pattern_hi,
    output logic [7:0]  o_attr_lo,
    output logic [7:0]  o_attr_hi,
    output logic        o_inc_coarse_x,
    output logic        o_inc_y,
    output logic        o_copy_x,
    output logic        o_copy_y
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_e;

    localparam logic [13:0] c_PLANE_HI = 14'h0008;

    state_e     state_q,   state_d;
    logic [2:0] phase_q,   phase_d;
    logic [7:0] nt_q,      nt_d;
    logic [1:0] at_bits_q, at_bits_d;
    logic [7:0] pt_lo_q,   pt_lo_d;
    logic [7:0] pt_hi_q,   pt_hi_d;
    logic       tail_q,    tail_d;

    logic        w_active;
    logic        w_go;
    logic        w_entry;
    logic        w_fetch;
    logic        w_seg_end;
    logic        w_tail;
    logic        w_dummy;
    logic [2:0]  w_phase;
    logic [2:0]  w_at_shift;
    logic [13:0] w_nt_addr;
    logic [13:0] w_at_addr;
    logic [13:0] w_pt_addr;

    always_comb begin
        w_active  = i_rendering_enabled & i_render_line;
        w_go      = i_ce & w_active & ~i_reset;
        w_entry   = (i_dot == 9'd1) | (i_dot == 9'd321);
        // The entry dot already fetches (phase 0) while the FSM is still IDLE.
        w_fetch   = w_active & ((state_q == S_FETCH) | w_entry);
        w_phase   = (state_q == S_FETCH) ? phase_q : (i_dot[2:0] - 3'd1);
        w_seg_end = (i_dot == 9'd256) | (i_dot == 9'd336);
        // Trailing load/shift dot after a segment that ran to completion.
        w_tail    = w_active & tail_q & ((i_dot == 9'd257) | (i_dot == 9'd337));
        w_dummy   = w_active & ((i_dot == 9'd337) | (i_dot == 9'd339));

        w_nt_addr  = NT_BASE | {2'b00, i_v[11:0]};
        w_at_addr  = NT_BASE | AT_OFFSET
                   | {2'b00, i_v[11:10], 4'b0000, i_v[9:7], i_v[4:2]};
        w_pt_addr  = {1'b0, i_bg_table, nt_q, 1'b0, i_v[14:12]};
        w_at_shift = {i_v[6], i_v[1], 1'b0};
    end

    always_comb begin
        o_vram_rd      = 1'b0;
        o_vram_addr    = 14'h0000;
        o_bg_load      = 1'b0;
        o_bg_shift     = 1'b0;
        o_inc_coarse_x = 1'b0;
        o_inc_y        = 1'b0;
        o_copy_x       = 1'b0;
        o_copy_y       = 1'b0;
        if (w_go) begin
            if (w_fetch && !w_phase[0]) begin
                o_vram_rd = 1'b1;
                unique case (w_phase[2:1])
                    2'd0:    o_vram_addr = w_nt_addr;
                    2'd1:    o_vram_addr = w_at_addr;
                    2'd2:    o_vram_addr = w_pt_addr;
                    default: o_vram_addr = w_pt_addr | c_PLANE_HI;
                endcase
            end else if (w_dummy) begin
                o_vram_rd   = 1'b1;
                o_vram_addr = w_nt_addr;
            end
            o_bg_load      = (w_fetch & ~w_entry & (w_phase == 3'd0)) | w_tail;
            o_bg_shift     = (w_fetch & ~w_entry) | w_tail;
            o_inc_coarse_x = w_fetch & (w_phase == 3'd7);
            o_inc_y        = w_fetch & (i_dot == 9'd256);
            o_copy_x       = w_tail & (i_dot == 9'd257);
            o_copy_y       = i_prerender & (i_dot >= 9'd280) & (i_dot <= 9'd304);
        end
    end

    assign o_pattern_lo = pt_lo_q;
    assign o_pattern_hi = pt_hi_q;
    assign o_attr_lo    = {8{at_bits_q[0]}};
    assign o_attr_hi    = {8{at_bits_q[1]}};

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        nt_d      = nt_q;
        at_bits_d = at_bits_q;
        pt_lo_d   = pt_lo_q;
        pt_hi_d   = pt_hi_q;
        tail_d    = tail_q;
        if (i_ce) begin
            if (w_fetch) begin
                state_d = w_seg_end ? S_IDLE : S_FETCH;
                phase_d = w_phase + 3'd1;
                tail_d  = w_seg_end;
                unique case (w_phase)
                    3'd1:    nt_d      = i_vram_data;
                    3'd3:    at_bits_d = 2'(i_vram_data >> w_at_shift);
                    3'd5:    pt_lo_d   = i_vram_data;
                    3'd7:    pt_hi_d   = i_vram_data;
                    default: ;
                endcase
            end else begin
                state_d = S_IDLE;
                tail_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            phase_q   <= 3'd0;
            nt_q      <= 8'h00;
            at_bits_q <= 2'd0;
            pt_lo_q   <= 8'h00;
            pt_hi_q   <= 8'h00;
            tail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            nt_q      <= nt_d;
            at_bits_q <= at_bits_d;
            pt_lo_q   <= pt_lo_d;
            pt_hi_q   <= pt_hi_d;
            tail_q    <= tail_d;
        end
    end

endmodule
`default_nettype wire
